snd_gain_mixer: RTL and testbench

//  Four-channel signed audio mixer with per-channel 8-bit gain, saturation and overflow flag.

---
 rtl/snd_mix_pkg.sv | 7 +
 rtl/snd_mix_sat.sv | 25 ++
 rtl/snd_gain_mixer.sv | 124 ++++++++++++
 tb/tb_snd_gain_mixer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snd_mix_pkg.sv
// Shared constants for the snd_gain_mixer slice: gain format (4.4 unsigned) and channel count.
package snd_mix_pkg;
   localparam int                GAIN_W     = 8;
   localparam int                GAIN_FRAC  = 4;
   localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'h10;
   localparam int                NUM_CH     = 4;
endpackage

// File: rtl/snd_mix_sat.sv
// Signed saturator: narrows a WIN-bit value to WOUT bits, clamping to the rails and flagging a clip.
module snd_mix_sat #(
   parameter int WIN  = 27,
   parameter int WOUT = 16
) (
   input  logic signed [WIN-1:0]  i_val,
   output logic signed [WOUT-1:0] o_val,
   output logic                   o_clip
);
   logic w_fits;

   // The value fits when every bit above the output sign bit copies the input sign.
   assign w_fits = (i_val[WIN-1:WOUT-1] == {(WIN-WOUT+1){i_val[WIN-1]}});

   always_comb begin
      o_clip = !w_fits;
      if (w_fits) begin
         o_val = i_val[WOUT-1:0];
      end else if (i_val[WIN-1]) begin
         o_val = {1'b1, {(WOUT-1){1'b0}}};
      end else begin
         o_val = {1'b0, {(WOUT-1){1'b1}}};
      end
   end
endmodule

// File: rtl/snd_gain_mixer.sv
// Four-channel signed mixer: per-channel 4.4 gain, sum, >>>4, saturate; two cen ticks of latency.
// Optional SND_MIX_PEAK_HOLD_EN stretches the peak flag for PEAK_HOLD cen ticks after a clip.
module snd_gain_mixer
   import snd_mix_pkg::*;
#(
   parameter int W0        = 16,
   parameter int W1        = 16,
   parameter int W2        = 16,
   parameter int W3        = 16,
   parameter int WOUT      = 16,
   parameter int PEAK_HOLD = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cen,
   input  logic signed [W0-1:0]   ch0,
   input  logic signed [W1-1:0]   ch1,
   input  logic signed [W2-1:0]   ch2,
   input  logic signed [W3-1:0]   ch3,
   input  logic [GAIN_W-1:0]      gain0,
   input  logic [GAIN_W-1:0]      gain1,
   input  logic [GAIN_W-1:0]      gain2,
   input  logic [GAIN_W-1:0]      gain3,
   output logic signed [WOUT-1:0] mixed,
   output logic                   peak
);
   localparam int PW = WOUT + GAIN_W + 1;
   localparam int SW = WOUT + 11;

   logic signed [WOUT-1:0] w_ext  [NUM_CH];
   logic [GAIN_W-1:0]      w_gain [NUM_CH];
   logic signed [PW-1:0]   w_prod [NUM_CH];
   logic signed [PW-1:0]   r_prod [NUM_CH];
   logic signed [SW-1:0]   w_sum;
   logic signed [SW-1:0]   w_scaled;
   logic signed [WOUT-1:0] w_sat;
   logic                   w_clip;
   logic signed [WOUT-1:0] r_mixed;
   logic                   r_peak;

   // Channels wider than the output are not supported; this empty block marks such a build.
   if (W0 > WOUT || W1 > WOUT || W2 > WOUT || W3 > WOUT || PEAK_HOLD < 1) begin : g_invalid_params
   end

   assign w_ext[0]  = WOUT'(ch0);
   assign w_ext[1]  = WOUT'(ch1);
   assign w_ext[2]  = WOUT'(ch2);
   assign w_ext[3]  = WOUT'(ch3);
   assign w_gain[0] = gain0;
   assign w_gain[1] = gain1;
   assign w_gain[2] = gain2;
   assign w_gain[3] = gain3;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mul
      assign w_prod[gi] = PW'(w_ext[gi]) * $signed(PW'({1'b0, w_gain[gi]}));
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rst_n) begin
            r_prod[i] <= '0;
         end else if (cen) begin
            r_prod[i] <= w_prod[i];
         end
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_sum = w_sum + SW'(r_prod[i]);
      end
   end

   assign w_scaled = w_sum >>> GAIN_FRAC;

   snd_mix_sat #(
      .WIN  (SW),
      .WOUT (WOUT)
   ) u_sat (
      .i_val  (w_scaled),
      .o_val  (w_sat),
      .o_clip (w_clip)
   );

`ifdef SND_MIX_PEAK_HOLD_EN
   localparam int HOLD_CW = $clog2(PEAK_HOLD + 1);

   logic [HOLD_CW-1:0] r_hold_cnt;

   // Peak stays up for the clip tick plus PEAK_HOLD clean ticks after it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mixed    <= '0;
         r_peak     <= 1'b0;
         r_hold_cnt <= '0;
      end else if (cen) begin
         r_mixed <= w_sat;
         if (w_clip) begin
            r_hold_cnt <= HOLD_CW'(PEAK_HOLD);
            r_peak     <= 1'b1;
         end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
            r_peak     <= 1'b1;
         end else begin
            r_peak     <= 1'b0;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mixed <= '0;
         r_peak  <= 1'b0;
      end else if (cen) begin
         r_mixed <= w_sat;
         r_peak  <= w_clip;
      end
   end
`endif

   assign mixed = r_mixed;
   assign peak  = r_peak;
endmodule

// File: tb/tb_snd_gain_mixer.sv
// Directed bench for snd_gain_mixer with a 10-bit ch1; define SND_MIX_PEAK_HOLD_EN to add the hold test.
module tb_snd_gain_mixer;
   import snd_mix_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cen;
   logic signed [15:0] ch0;
   logic signed [9:0]  ch1;
   logic signed [15:0] ch2;
   logic signed [15:0] ch3;
   logic [7:0]         gain0, gain1, gain2, gain3;
   logic signed [15:0] mixed;
   logic               peak;

   int n_checks = 0;
   int n_fail   = 0;

   snd_gain_mixer #(
      .W0        (16),
      .W1        (10),
      .W2        (16),
      .W3        (16),
      .WOUT      (16),
      .PEAK_HOLD (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cen   (cen),
      .ch0   (ch0),
      .ch1   (ch1),
      .ch2   (ch2),
      .ch3   (ch3),
      .gain0 (gain0),
      .gain1 (gain1),
      .gain2 (gain2),
      .gain3 (gain3),
      .mixed (mixed),
      .peak  (peak)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic signed [15:0] c0, input logic signed [9:0] c1,
                        input logic signed [15:0] c2, input logic signed [15:0] c3,
                        input logic [7:0] g0, input logic [7:0] g1,
                        input logic [7:0] g2, input logic [7:0] g3);
      ch0 = c0; ch1 = c1; ch2 = c2; ch3 = c3;
      gain0 = g0; gain1 = g1; gain2 = g2; gain3 = g3;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cen   = 1'b0;
      apply(16'sd1234, -10'sd7, 16'sd99, -16'sd5, 8'h10, 8'h10, 8'h10, 8'h10);
      tick();
      tick();
      $display("test_reset: mixed=%0d peak=%0b", mixed, peak);
      n_checks++;
      if (mixed !== 16'sd0) begin
         n_fail++; $display("FAIL reset_mixed: got %0d expected 0", mixed);
      end
      n_checks++;
      if (peak !== 1'b0) begin
         n_fail++; $display("FAIL reset_peak: got %0b expected 0", peak);
      end
      rst_n = 1'b1;
      cen   = 1'b1;
   endtask

   task automatic test_unity();
      apply(16'sd1000, 10'sd0, 16'sd0, 16'sd0, GAIN_UNITY, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      $display("test_unity: mixed=%0d peak=%0b", mixed, peak);
      n_checks++;
      if (mixed !== 16'sd1000 || peak !== 1'b0) begin
         n_fail++; $display("FAIL unity: got %0d/%0b expected 1000/0", mixed, peak);
      end
   endtask

   task automatic test_latency();
      apply(16'sd2000, 10'sd0, 16'sd0, 16'sd0, 8'h10, 8'h00, 8'h00, 8'h00);
      tick();
      $display("test_latency: after one tick mixed=%0d", mixed);
      n_checks++;
      if (mixed !== 16'sd1000) begin
         n_fail++; $display("FAIL latency_tick1: got %0d expected 1000", mixed);
      end
      tick();
      $display("test_latency: after two ticks mixed=%0d", mixed);
      n_checks++;
      if (mixed !== 16'sd2000) begin
         n_fail++; $display("FAIL latency_tick2: got %0d expected 2000", mixed);
      end
   endtask

   task automatic test_mix();
      // 1000*48 - 50*8 = 47600 -> 2975; ch2/ch3 muted by gain 0
      apply(16'sd1000, -10'sd50, 16'sd12345, -16'sd777, 8'h30, 8'h08, 8'h00, 8'h00);
      tick();
      tick();
      $display("test_mix: mixed=%0d peak=%0b", mixed, peak);
      n_checks++;
      if (mixed !== 16'sd2975 || peak !== 1'b0) begin
         n_fail++; $display("FAIL mix_x3: got %0d/%0b expected 2975/0", mixed, peak);
      end
   endtask

   task automatic test_four_ch();
      // 1600 + 6400 - 4800 + 400 = 3600 -> 225
      apply(16'sd100, 10'sd200, -16'sd300, 16'sd50, 8'h10, 8'h20, 8'h10, 8'h08);
      tick();
      tick();
      $display("test_four_ch: mixed=%0d peak=%0b", mixed, peak);
      n_checks++;
      if (mixed !== 16'sd225 || peak !== 1'b0) begin
         n_fail++; $display("FAIL four_ch: got %0d/%0b expected 225/0", mixed, peak);
      end
   endtask

   task automatic test_mute();
      apply(16'sd30000, -10'sd500, -16'sd30000, 16'sd1, 8'h00, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      $display("test_mute: mixed=%0d peak=%0b", mixed, peak);
      n_checks++;
      if (mixed !== 16'sd0 || peak !== 1'b0) begin
         n_fail++; $display("FAIL mute: got %0d/%0b expected 0/0", mixed, peak);
      end
   endtask

   task automatic test_floor();
      apply(-16'sd1, 10'sd0, 16'sd0, 16'sd0, 8'h08, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      $display("test_floor: -1*0.5 mixed=%0d", mixed);
      n_checks++;
      if (mixed !== -16'sd1) begin
         n_fail++; $display("FAIL floor_neg: got %0d expected -1", mixed);
      end
      apply(16'sd1, 10'sd0, 16'sd0, 16'sd0, 8'h08, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      $display("test_floor: 1*0.5 mixed=%0d", mixed);
      n_checks++;
      if (mixed !== 16'sd0) begin
         n_fail++; $display("FAIL floor_pos: got %0d expected 0", mixed);
      end
   endtask

   task automatic test_boundary();
      apply(16'sd32767, 10'sd0, 16'sd0, 16'sd0, 8'h10, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      $display("test_boundary: max mixed=%0d peak=%0b", mixed, peak);
      n_checks++;
      if (mixed !== 16'sh7FFF || peak !== 1'b0) begin
         n_fail++; $display("FAIL bound_max: got %0d/%0b expected 32767/0", mixed, peak);
      end
      apply(-16'sd32768, 10'sd0, 16'sd0, 16'sd0, 8'h10, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      $display("test_boundary: min mixed=%0d peak=%0b", mixed, peak);
      n_checks++;
      if (mixed !== 16'sh8000 || peak !== 1'b0) begin
         n_fail++; $display("FAIL bound_min: got %0d/%0b expected -32768/0", mixed, peak);
      end
   endtask

   task automatic test_clip();
      apply(16'sh7000, 10'sd0, 16'sd0, 16'sd0, 8'h30, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      $display("test_clip: pos mixed=%0d peak=%0b", mixed, peak);
      n_checks++;
      if (mixed !== 16'sh7FFF || peak !== 1'b1) begin
         n_fail++; $display("FAIL clip_pos: got %0d/%0b expected 32767/1", mixed, peak);
      end
      apply(-16'sd20000, 10'sd0, 16'sd0, 16'sd0, 8'h20, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      $display("test_clip: neg mixed=%0d peak=%0b", mixed, peak);
      n_checks++;
      if (mixed !== 16'sh8000 || peak !== 1'b1) begin
         n_fail++; $display("FAIL clip_neg: got %0d/%0b expected -32768/1", mixed, peak);
      end
      // 32767*17/16 = 34814 -> just over the rail
      apply(16'sd32767, 10'sd0, 16'sd0, 16'sd0, 8'h11, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      $display("test_clip: edge mixed=%0d peak=%0b", mixed, peak);
      n_checks++;
      if (mixed !== 16'sh7FFF || peak !== 1'b1) begin
         n_fail++; $display("FAIL clip_edge: got %0d/%0b expected 32767/1", mixed, peak);
      end
   endtask

   task automatic test_cen_hold();
      apply(16'sh7000, 10'sd0, 16'sd0, 16'sd0, 8'h30, 8'h00, 8'h00, 8'h00);
      tick();
      tick();
      cen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         apply(16'(k * 37), 10'(k), -16'(k * 11), 16'(k), 8'h10, 8'h10, 8'h10, 8'h10);
         tick();
         $display("test_cen_hold: clk %0d mixed=%0d peak=%0b", k, mixed, peak);
         n_checks++;
         if (mixed !== 16'sh7FFF || peak !== 1'b1) begin
            n_fail++; $display("FAIL cen_hold_%0d: got %0d/%0b expected 32767/1", k, mixed, peak);
         end
      end
      cen = 1'b1;
   endtask

   task automatic test_reset_mid();
      apply(16'sh7000, 10'sd0, 16'sd0, 16'sd0, 8'h30, 8'h00, 8'h00, 8'h00);
      tick();
      rst_n = 1'b0;
      tick();
      $display("test_reset_mid: in reset mixed=%0d peak=%0b", mixed, peak);
      n_checks++;
      if (mixed !== 16'sd0 || peak !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid: got %0d/%0b expected 0/0", mixed, peak);
      end
      rst_n = 1'b1;
      apply(16'sd1000, 10'sd0, 16'sd0, 16'sd0, 8'h10, 8'h00, 8'h00, 8'h00);
      tick();
      n_checks++;
      if (mixed !== 16'sd0) begin
         n_fail++; $display("FAIL reset_mid_tick1: got %0d expected 0", mixed);
      end
      tick();
      $display("test_reset_mid: after release mixed=%0d", mixed);
      n_checks++;
      if (mixed !== 16'sd1000 || peak !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_tick2: got %0d/%0b expected 1000/0", mixed, peak);
      end
   endtask

`ifdef SND_MIX_PEAK_HOLD_EN
   task automatic test_peak_hold();
      pulse_reset();
      apply(16'sh7000, 10'sd0, 16'sd0, 16'sd0, 8'h30, 8'h00, 8'h00, 8'h00);
      tick();
      apply(16'sd100, 10'sd0, 16'sd0, 16'sd0, 8'h10, 8'h00, 8'h00, 8'h00);
      tick();
      n_checks++;
      if (mixed !== 16'sh7FFF || peak !== 1'b1) begin
         n_fail++; $display("FAIL hold_clip: got %0d/%0b expected 32767/1", mixed, peak);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         $display("test_peak_hold: clean tick %0d mixed=%0d peak=%0b", k, mixed, peak);
         n_checks++;
         if (mixed !== 16'sd100 || peak !== 1'b1) begin
            n_fail++; $display("FAIL hold_%0d: got %0d/%0b expected 100/1", k, mixed, peak);
         end
      end
      tick();
      n_checks++;
      if (peak !== 1'b0) begin
         n_fail++; $display("FAIL hold_release: got %0b expected 0", peak);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_unity();
      test_latency();
      test_mix();
      test_four_ch();
      test_mute();
      test_floor();
      test_boundary();
      test_clip();
      pulse_reset();
      test_cen_hold();
      test_reset_mid();
`ifdef SND_MIX_PEAK_HOLD_EN
      test_peak_hold();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
